// File: rtl/common_pkg.sv
// Shared core types and sizing constants for the GPR file and its scoreboard.
package common;
  localparam int unsigned NUM_GPR = 32;
  localparam int unsigned PEND_W  = 2;

  typedef logic [4:0]  creg_addr_t;
  typedef logic [63:0] u64;
endpackage

// File: rtl/regfile_scoreboard_scoreboard.sv
// Per-GPR pending-writer counters plus operand and reservation hazard detection.
module scoreboard
  import common::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_retire,
  input  creg_addr_t i_wb_dst,
  input  creg_addr_t i_ra1,
  input  creg_addr_t i_ra2,
  input  logic       i_use1,
  input  logic       i_use2,
  input  logic       i_iss_valid,
  input  logic       i_iss_regwrite,
  input  creg_addr_t i_iss_dst,
  input  logic       i_sb_clear,
  output logic       o_stall,
  output logic       o_sb_err
);

  localparam logic [PEND_W-1:0] CntZero = '0;
  localparam logic [PEND_W-1:0] CntOne  = PEND_W'(1);
  localparam logic [PEND_W-1:0] CntMax  = '1;

  logic [PEND_W-1:0] r_cnt   [NUM_GPR];
  logic [PEND_W-1:0] w_cnt_d [NUM_GPR];
  logic              r_err;
  logic              w_iss_req;
  logic              w_haz1;
  logic              w_haz2;
  logic              w_haz_res;
  logic              w_issue;
  logic              w_underflow;

  // A single outstanding writer retiring this cycle is covered by the bypass.
  function automatic logic operand_hazard(input logic use_op, input creg_addr_t ra,
                                          input logic [PEND_W-1:0] cnt,
                                          input logic retire_same);
    return use_op && (ra != '0) && (cnt != CntZero) && !((cnt == CntOne) && retire_same);
  endfunction

  assign w_iss_req   = i_iss_valid && i_iss_regwrite && (i_iss_dst != '0);
  assign w_haz1      = operand_hazard(i_use1, i_ra1, r_cnt[i_ra1],
                                      i_retire && (i_wb_dst == i_ra1));
  assign w_haz2      = operand_hazard(i_use2, i_ra2, r_cnt[i_ra2],
                                      i_retire && (i_wb_dst == i_ra2));
  assign w_haz_res   = w_iss_req && (r_cnt[i_iss_dst] == CntMax)
                       && !(i_retire && (i_wb_dst == i_iss_dst));
  assign o_stall     = w_haz1 || w_haz2 || w_haz_res;
  assign w_issue     = w_iss_req && !o_stall;
  assign w_underflow = i_retire && (r_cnt[i_wb_dst] == CntZero);
  assign o_sb_err    = r_err;

  always_comb begin
    w_cnt_d = r_cnt;
    for (int unsigned i = 1; i < NUM_GPR; i++) begin
      if (i_sb_clear) begin
        w_cnt_d[i] = (w_issue && (i_iss_dst == creg_addr_t'(i))) ? CntOne : CntZero;
      end else if (w_issue && (i_iss_dst == creg_addr_t'(i))
                   && !(i_retire && (i_wb_dst == creg_addr_t'(i)))) begin
        w_cnt_d[i] = r_cnt[i] + CntOne;
      end else if (i_retire && (i_wb_dst == creg_addr_t'(i))
                   && !(w_issue && (i_iss_dst == creg_addr_t'(i)))
                   && (r_cnt[i] != CntZero)) begin
        w_cnt_d[i] = r_cnt[i] - CntOne;
      end
    end
    w_cnt_d[0] = CntZero;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_GPR; i++) r_cnt[i] <= CntZero;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      r_err <= r_err || w_underflow;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32x64 GPR file with write-through bypass, wrapped around the pending-writer scoreboard.
module regfile_scoreboard
  import common::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wb_valid,
  input  logic       wb_regwrite,
  input  creg_addr_t wb_dst,
  input  u64         wb_data,
  input  creg_addr_t ra1,
  input  creg_addr_t ra2,
  output u64         rd1,
  output u64         rd2,
  input  logic       use1,
  input  logic       use2,
  input  logic       iss_valid,
  input  logic       iss_regwrite,
  input  creg_addr_t iss_dst,
  input  logic       sb_clear,
  output logic       stall,
  output logic       sb_err
);

  u64   r_regs [NUM_GPR];
  logic w_wr_en;

  assign w_wr_en = wb_valid && wb_regwrite && (wb_dst != '0);

  // Entry 0 is never written since w_wr_en excludes x0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_GPR; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[wb_dst] <= wb_data;
    end
  end

  always_comb begin
    rd1 = r_regs[ra1];
    rd2 = r_regs[ra2];
    if (w_wr_en && (wb_dst == ra1)) rd1 = wb_data;
    if (w_wr_en && (wb_dst == ra2)) rd2 = wb_data;
    if (ra1 == '0) rd1 = '0;
    if (ra2 == '0) rd2 = '0;
  end

  scoreboard u_scoreboard (
    .clk            (clk),
    .reset          (reset),
    .i_retire       (w_wr_en),
    .i_wb_dst       (wb_dst),
    .i_ra1          (ra1),
    .i_ra2          (ra2),
    .i_use1         (use1),
    .i_use2         (use2),
    .i_iss_valid    (iss_valid),
    .i_iss_regwrite (iss_regwrite),
    .i_iss_dst      (iss_dst),
    .i_sb_clear     (sb_clear),
    .o_stall        (stall),
    .o_sb_err       (sb_err)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus random stimulus against an array/int reference model of the GPR scoreboard.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_regwrite;
  logic [4:0]  wb_dst;
  logic [63:0] wb_data;
  logic [4:0]  ra1, ra2;
  logic [63:0] rd1, rd2;
  logic        use1, use2;
  logic        iss_valid, iss_regwrite;
  logic [4:0]  iss_dst;
  logic        sb_clear;
  logic        stall, sb_err;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_err;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .wb_valid     (wb_valid),
    .wb_regwrite  (wb_regwrite),
    .wb_dst       (wb_dst),
    .wb_data      (wb_data),
    .ra1          (ra1),
    .ra2          (ra2),
    .rd1          (rd1),
    .rd2          (rd2),
    .use1         (use1),
    .use2         (use2),
    .iss_valid    (iss_valid),
    .iss_regwrite (iss_regwrite),
    .iss_dst      (iss_dst),
    .sb_clear     (sb_clear),
    .stall        (stall),
    .sb_err       (sb_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_retire();
    return wb_valid && wb_regwrite && (wb_dst != 0);
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] ra);
    if (ra == 0) return 64'd0;
    if (m_retire() && wb_dst == ra) return wb_data;
    return m_regs[ra];
  endfunction

  function automatic bit m_op_haz(input bit u, input logic [4:0] ra);
    if (!u || ra == 0 || m_cnt[ra] == 0) return 0;
    return !(m_cnt[ra] == 1 && m_retire() && wb_dst == ra);
  endfunction

  function automatic bit m_stall();
    bit res;
    res = iss_valid && iss_regwrite && iss_dst != 0 && m_cnt[iss_dst] == 3
          && !(m_retire() && wb_dst == iss_dst);
    return m_op_haz(use1, ra1) || m_op_haz(use2, ra2) || res;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
    m_err = 0;
  endtask

  task automatic idle();
    wb_valid = 0; wb_regwrite = 0; wb_dst = 0; wb_data = '0;
    ra1 = 0; ra2 = 0; use1 = 0; use2 = 0;
    iss_valid = 0; iss_regwrite = 0; iss_dst = 0; sb_clear = 0;
  endtask

  // Called just after inputs were driven on a falling edge; ends on the next falling edge.
  task automatic step(input string tag);
    bit st, issue, ret;
    int inc, dec;
    #1;
    st = m_stall();
    chk({tag, ".rd1"}, rd1, m_read(ra1));
    chk({tag, ".rd2"}, rd2, m_read(ra2));
    chk({tag, ".stall"}, {63'd0, stall}, {63'd0, st});
    chk({tag, ".sb_err"}, {63'd0, sb_err}, {63'd0, m_err});
    ret   = m_retire();
    issue = iss_valid && iss_regwrite && iss_dst != 0 && !st;
    @(posedge clk);
    if (ret) begin
      if (m_cnt[wb_dst] == 0) m_err = 1;
      m_regs[wb_dst] = wb_data;
    end
    for (int r = 1; r < 32; r++) begin
      inc = (issue && iss_dst == r) ? 1 : 0;
      dec = (ret && wb_dst == r) ? 1 : 0;
      if (sb_clear) m_cnt[r] = inc;
      else m_cnt[r] = (m_cnt[r] + inc - dec < 0) ? 0 : m_cnt[r] + inc - dec;
    end
    @(negedge clk);
  endtask

  task automatic retire(input logic [4:0] d, input logic [63:0] v);
    wb_valid = 1; wb_regwrite = 1; wb_dst = d; wb_data = v;
  endtask

  task automatic issue_to(input logic [4:0] d);
    iss_valid = 1; iss_regwrite = 1; iss_dst = d;
  endtask

  initial begin
    idle();
    m_reset();
    reset = 0;
    #12;
    ra1 = 5; ra2 = 0; use1 = 1;
    #1;
    chk("rst.rd1", rd1, 64'd0);
    chk("rst.stall", {63'd0, stall}, 64'd0);
    chk("rst.sb_err", {63'd0, sb_err}, 64'd0);
    @(negedge clk);
    reset = 1;
    idle();

    // Write-through bypass and hold.
    retire(5, 64'hDEAD_BEEF); ra1 = 5;    step("byp");
    idle(); ra1 = 5; ra2 = 5;             step("byp_hold");

    // x0 writes and issues are ignored.
    retire(0, 64'h1234); issue_to(0); ra1 = 0; use1 = 1; step("x0_wr");
    idle(); ra1 = 0; use1 = 1;                            step("x0_rd");

    // RAW stall until retirement.
    idle(); issue_to(7);                   step("raw_iss");
    idle(); ra1 = 7; use1 = 1;             step("raw_wait0");
    idle(); ra1 = 7; use1 = 1;             step("raw_wait1");
    retire(7, 64'h77); ra1 = 7; use1 = 1;  step("raw_ret");
    idle(); ra1 = 7; use1 = 1;             step("raw_done");

    // Saturation at three writers.
    for (int k = 0; k < 3; k++) begin
      idle(); issue_to(3);                 step("sat_iss");
    end
    idle(); issue_to(3);                   step("sat_4th");
    retire(3, 64'h33); issue_to(3);        step("sat_4th_ret");
    retire(3, 64'h34); ra2 = 3; use2 = 1;  step("sat_cnt3");
    for (int k = 0; k < 2; k++) begin
      idle(); retire(3, 64'h35 + k);       step("sat_drain");
    end
    idle(); ra2 = 3; use2 = 1;             step("sat_empty");

    // Underflow and clear.
    idle(); retire(9, 64'h99);             step("uf_ret");
    idle(); ra1 = 9;                       step("uf_sticky");
    idle(); issue_to(4);                   step("clr_iss_a");
    idle(); issue_to(4);                   step("clr_iss_b");
    idle(); issue_to(4); sb_clear = 1;     step("clr_iss");
    idle(); retire(4, 64'h44); ra1 = 4; use1 = 1; step("clr_cnt1");
    idle(); ra1 = 4; use1 = 1;             step("clr_after");

    // Random traffic concentrated on x0..x7 to exercise hazards.
    for (int n = 0; n < 400; n++) begin
      wb_valid     = 1'($urandom_range(0, 1));
      wb_regwrite  = ($urandom_range(0, 3) != 0);
      wb_dst       = 5'($urandom_range(0, 7));
      wb_data      = {$urandom, $urandom};
      ra1          = 5'($urandom_range(0, 7));
      ra2          = 5'($urandom_range(0, 7));
      use1         = 1'($urandom_range(0, 1));
      use2         = 1'($urandom_range(0, 1));
      iss_valid    = ($urandom_range(0, 2) != 0);
      iss_regwrite = ($urandom_range(0, 3) != 0);
      iss_dst      = 5'($urandom_range(0, 7));
      sb_clear     = ($urandom_range(0, 19) == 0);
      step("rnd");
    end

    // Asynchronous reset with reservations in flight.
    idle(); retire(6, 64'd5);              step("ar_wr");
    idle(); issue_to(6);                   step("ar_iss_a");
    idle(); issue_to(6);                   step("ar_iss_b");
    idle(); ra1 = 6; use1 = 1;             step("ar_pre");
    @(posedge clk);
    #2;
    reset = 0;
    #1;
    chk("ar.rd1", rd1, 64'd0);
    chk("ar.stall", {63'd0, stall}, 64'd0);
    chk("ar.sb_err", {63'd0, sb_err}, 64'd0);
    m_reset();
    @(negedge clk);
    reset = 1;
    idle(); ra1 = 6; use1 = 1;             step("ar_post");
    idle(); issue_to(6); ra2 = 6;          step("ar_reissue");
    idle(); ra2 = 6; use2 = 1;             step("ar_hazard");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
